// File: rtl/flappy_pkg.sv
// flappy_pkg: shared game state encoding, playfield geometry and reset positions
package flappy_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2, GAME_OVER = 2'd3} game_state_t;
  localparam int BIRD_X   = 3;
  localparam int GAP_SIZE = 4;
  localparam int GAP_MAX  = 12;
  localparam logic [3:0] BIRD_Y0 = 4'd7;
  localparam logic [3:0] PIPE_X0 = 4'd15;
  localparam logic [3:0] GAP_Y0  = 4'd6;
endpackage

// File: rtl/flappy_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR (taps 8,6,5,4, seed A5) stepping every clk; ports clk, reset, q[7:0]
module lfsr8 (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);
  always_ff @(posedge clk) q <= reset ? 8'hA5 : {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
endmodule

// File: rtl/flappy_game_core.sv
// flappy_game_core: flappy bird game logic; in clk/reset/flap_btn/pause_btn, out bird_x/bird_y/pipe_x/gap_y/game_state/blink_counter/score
module flappy_game_core
  import flappy_pkg::*;
#(
  parameter int TICK_DIV = 12500000,
  parameter int GRAV_DIV = 2,
  parameter int FLAP_H   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flap_btn,
  input  logic        pause_btn,
  output logic [3:0]  bird_x,
  output logic [3:0]  bird_y,
  output logic [3:0]  pipe_x,
  output logic [3:0]  gap_y,
  output logic [1:0]  game_state,
  output logic [24:0] blink_counter,
  output logic [7:0]  score
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int GW = $clog2(GRAV_DIV + 1);
  game_state_t state, state_n;
  logic flap_q, pause_q, flap_p, pause_p, tick, pend, fl, grav_wrap, col, stay_play;
  logic [PW-1:0] presc;
  logic [GW-1:0] grav, grav_n;
  logic [3:0] lq, lfsr_unused, by_n, px_n, gy_n;
  lfsr8 u_lfsr (.clk(clk), .reset(reset), .q({lfsr_unused, lq}));
  assign pause_p   = pause_btn & ~pause_q;
  assign flap_p    = flap_btn & ~flap_q & ~pause_p;
  assign tick      = state == PLAY && !pause_p && presc == PW'(TICK_DIV - 1);
  assign fl        = pend | flap_p;
  assign grav_wrap = grav == GW'(GRAV_DIV - 1);
  assign stay_play = state == PLAY && state_n == PLAY;
  always_comb begin
    by_n   = fl ? (bird_y >= 4'(FLAP_H) ? bird_y - 4'(FLAP_H) : 4'd0)
                : (grav_wrap && bird_y != 4'd15) ? bird_y + 4'd1 : bird_y;
    grav_n = fl ? grav : grav_wrap ? '0 : grav + GW'(1);
    px_n   = pipe_x == 4'd0 ? 4'd15 : pipe_x - 4'd1;
    gy_n   = pipe_x == 4'd0 ? (lq <= 4'(GAP_MAX) ? lq : lq - 4'(GAP_SIZE)) : gap_y;
    col    = (px_n == 4'(BIRD_X) && (by_n < gy_n || by_n > gy_n + 4'(GAP_SIZE - 1))) || by_n == 4'd15;
  end
  always_comb
    state_n = state == IDLE      && flap_p        ? PLAY      :
              state == PLAY      && pause_p       ? PAUSE     :
              state == PLAY      && tick && col   ? GAME_OVER :
              state == PAUSE     && pause_p       ? PLAY      :
              state == GAME_OVER && flap_p        ? IDLE      : state;
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    game_state = state;
    bird_x     = 4'(BIRD_X);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      flap_q        <= 1'b0;
      pause_q       <= 1'b0;
      blink_counter <= '0;
      presc         <= '0;
      pend          <= 1'b0;
      grav          <= '0;
      bird_y        <= BIRD_Y0;
      pipe_x        <= PIPE_X0;
      gap_y         <= GAP_Y0;
      score         <= 8'd0;
    end else begin
      flap_q        <= flap_btn;
      pause_q       <= pause_btn;
      blink_counter <= blink_counter + 25'd1;
      presc         <= stay_play && !tick ? presc + PW'(1) : '0;
      pend          <= stay_play && !tick && fl;
      if (tick) begin
        bird_y <= by_n;
        pipe_x <= px_n;
        gap_y  <= gy_n;
        grav   <= grav_n;
        if (!col && pipe_x == 4'(BIRD_X) && score != 8'd255) score <= score + 8'd1;
      end else if (state == GAME_OVER && flap_p) begin
        bird_y <= BIRD_Y0;
        pipe_x <= PIPE_X0;
        gap_y  <= GAP_Y0;
        grav   <= '0;
        score  <= 8'd0;
      end
    end
  end
endmodule

// File: tb/tb_flappy_game_core.sv
// tb_flappy_game_core: directed literal checks plus randomized play against a behavioural game model
module tb_flappy_game_core;
  localparam int TD = 4, GD = 2, FH = 2;
  logic clk = 0, reset = 1, flap_btn = 0, pause_btn = 0;
  logic [3:0] bird_x, bird_y, pipe_x, gap_y;
  logic [1:0] game_state;
  logic [24:0] blink_counter;
  logic [7:0] score;
  int total = 0, bad = 0;
  bit running = 0;
  int m_state, m_by, m_px, m_gy, m_sc, m_blink, m_presc, m_grav, m_pend, m_lfsr, pf, ppv;
  flappy_game_core #(.TICK_DIV(TD), .GRAV_DIV(GD), .FLAP_H(FH)) dut (
    .clk(clk), .reset(reset), .flap_btn(flap_btn), .pause_btn(pause_btn),
    .bird_x(bird_x), .bird_y(bird_y), .pipe_x(pipe_x), .gap_y(gap_y),
    .game_state(game_state), .blink_counter(blink_counter), .score(score)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", n, a, e, $time);
    end
  endtask
  task automatic mstep();
    int pp, fp, l, nb, np, ng;
    bit tk, col;
    if (reset) begin
      m_state = 0; m_by = 7; m_px = 15; m_gy = 6; m_sc = 0; m_blink = 0;
      m_presc = 0; m_grav = 0; m_pend = 0; m_lfsr = 'hA5; pf = 0; ppv = 0;
      return;
    end
    pp = int'(pause_btn) & ~ppv & 1;
    fp = int'(flap_btn) & ~pf & ~pp & 1;
    pf = int'(flap_btn);
    ppv = int'(pause_btn);
    m_blink = (m_blink + 1) % (1 << 25);
    l = m_lfsr % 16;
    m_lfsr = (m_lfsr * 2 + ($countones(m_lfsr & 'hB8) % 2)) % 256;
    case (m_state)
      0: if (fp == 1) m_state = 1;
      2: if (pp == 1) m_state = 1;
      3: if (fp == 1) begin m_state = 0; m_by = 7; m_px = 15; m_gy = 6; m_sc = 0; m_grav = 0; end
      default:
        if (pp == 1) begin m_state = 2; m_presc = 0; m_pend = 0; end
        else begin
          m_pend = m_pend | fp;
          tk = m_presc == TD - 1;
          m_presc = tk ? 0 : m_presc + 1;
          if (tk) begin
            if (m_pend == 1) nb = m_by >= FH ? m_by - FH : 0;
            else begin
              m_grav++;
              nb = m_by;
              if (m_grav == GD) begin m_grav = 0; nb = m_by < 15 ? m_by + 1 : 15; end
            end
            np = m_px == 0 ? 15 : m_px - 1;
            ng = m_px == 0 ? (l <= 12 ? l : l - 4) : m_gy;
            col = (np == 3 && (nb < ng || nb > ng + 3)) || nb == 15;
            if (!col && m_px == 3 && m_sc < 255) m_sc++;
            m_by = nb; m_px = np; m_gy = ng; m_pend = 0;
            if (col) m_state = 3;
          end
        end
    endcase
  endtask
  initial forever begin
    @(posedge clk);
    mstep();
  end
  initial forever begin
    @(negedge clk);
    if (running) begin
      chk("state", int'(game_state), m_state);
      chk("bird_x", int'(bird_x), 3);
      chk("bird_y", int'(bird_y), m_by);
      chk("pipe_x", int'(pipe_x), m_px);
      chk("gap_y", int'(gap_y), m_gy);
      chk("score", int'(score), m_sc);
      chk("blink", int'(blink_counter), m_blink);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start();
    reset = 1; step(); reset = 0; flap_btn = 1; step();
  endtask
  task automatic do_tick(input bit f);
    flap_btn = 0; step(); flap_btn = f; step(); flap_btn = 0; step(); step();
  endtask
  initial begin
    step(); step();
    reset = 0;
    running = 1;
    chk("lit_rst_state", int'(game_state), 0);
    chk("lit_rst_bird", int'(bird_y), 7);
    chk("lit_rst_pipe", int'(pipe_x), 15);
    chk("lit_rst_gap", int'(gap_y), 6);
    chk("lit_rst_score", int'(score), 0);
    chk("lit_rst_blink", int'(blink_counter), 0);
    start();
    chk("lit_play", int'(game_state), 1);
    do_tick(0);
    chk("lit_t1_pipe", int'(pipe_x), 14);
    chk("lit_t1_bird", int'(bird_y), 7);
    do_tick(0);
    chk("lit_t2_bird", int'(bird_y), 8);
    pause_btn = 1; step(); pause_btn = 0;
    chk("lit_pause", int'(game_state), 2);
    repeat (40) step();
    chk("lit_frozen_pipe", int'(pipe_x), 13);
    chk("lit_frozen_bird", int'(bird_y), 8);
    pause_btn = 1; step(); pause_btn = 0;
    chk("lit_resume", int'(game_state), 1);
    repeat (3) step();
    chk("lit_pre_tick_pipe", int'(pipe_x), 13);
    step();
    chk("lit_t3_pipe", int'(pipe_x), 12);
    repeat (8) do_tick(0);
    chk("lit_t11_bird", int'(bird_y), 12);
    chk("lit_t11_pipe", int'(pipe_x), 4);
    do_tick(0);
    chk("lit_hit_state", int'(game_state), 3);
    chk("lit_hit_pipe", int'(pipe_x), 3);
    chk("lit_hit_bird", int'(bird_y), 13);
    flap_btn = 1; step(); flap_btn = 0;
    chk("lit_idle_state", int'(game_state), 0);
    chk("lit_idle_bird", int'(bird_y), 7);
    chk("lit_idle_pipe", int'(pipe_x), 15);
    chk("lit_idle_score", int'(score), 0);
    start();
    repeat (4) do_tick(1);
    chk("lit_top_bird", int'(bird_y), 0);
    chk("lit_top_state", int'(game_state), 1);
    do_tick(0);
    chk("lit_top_hold", int'(bird_y), 0);
    do_tick(0);
    chk("lit_top_fall", int'(bird_y), 1);
    start();
    for (int t = 1; t <= 12; t++) do_tick(t == 4 || t == 8);
    chk("lit_gap_state", int'(game_state), 1);
    chk("lit_gap_pipe", int'(pipe_x), 3);
    chk("lit_gap_bird", int'(bird_y), 8);
    do_tick(0);
    chk("lit_score", int'(score), 1);
    chk("lit_score_pipe", int'(pipe_x), 2);
    for (int s = 0; s < 40; s++) begin
      int d;
      d = $urandom_range(2, 30);
      for (int c = 0; c < 500; c++) begin
        flap_btn  = $urandom_range(0, d) == 0;
        pause_btn = $urandom_range(0, 79) == 0;
        reset     = $urandom_range(0, 3999) == 0;
        step();
      end
    end
    reset = 0;
    step();
    running = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
